// File: rtl/router_pkg.sv
// Shared router definitions: default packet width and the source identifiers
// used by the x+ port arbiter.
package router_pkg;

    localparam int DATA_W = 82;

    typedef enum logic {
        SRC_TRANSIT = 1'b0,
        SRC_INJECT  = 1'b1
    } src_e;

endpackage

// File: rtl/xpos_arb_fifo.sv
// Single-clock source FIFO for the x+ arbiter. The head is read combinationally
// and the full flag depends only on registered pointers.
module xpos_arb_fifo
    import router_pkg::*;
#(
    parameter int DATA_W     = router_pkg::DATA_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [AW:0]       r_wr_ptr;
    logic [AW:0]       r_rd_ptr;
    logic              w_do_push;
    logic              w_do_pop;

    // The extra MSB on each pointer separates a full FIFO from an empty one.
    assign full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign empty     = (r_wr_ptr == r_rd_ptr);
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;
    assign dout      = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/xpos_port_arbiter.sv
// x+ output port: transit and inject FIFOs feed one registered output stage
// through a two-way round-robin arbiter, with saturating per-source grant counts.
module xpos_port_arbiter
    import router_pkg::*;
#(
    parameter int DATA_W     = router_pkg::DATA_W,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_xpos,
    input  logic              in_xpos_valid,
    output logic              in_xpos_ready,
    input  logic [DATA_W-1:0] inject_xpos,
    input  logic              inject_xpos_valid,
    output logic              inject_xpos_ready,
    output logic [DATA_W-1:0] out_xpos,
    output logic              out_xpos_valid,
    input  logic              out_xpos_ready,
    output logic [CNT_W-1:0]  grant_cnt_transit,
    output logic [CNT_W-1:0]  grant_cnt_inject
);

    logic [DATA_W-1:0] w_t_head;
    logic [DATA_W-1:0] w_i_head;
    logic              w_t_full;
    logic              w_t_empty;
    logic              w_i_full;
    logic              w_i_empty;
    logic              w_load_en;
    logic              w_any;
    logic              w_pop_t;
    logic              w_pop_i;
    src_e              w_grant;

    src_e              r_rr_last;
    logic [DATA_W-1:0] r_out_p1;
    logic              r_vld_p1;
    logic [CNT_W-1:0]  r_cnt_t;
    logic [CNT_W-1:0]  r_cnt_i;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    // Stage p0: per-source buffering
    xpos_arb_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo_transit (
        .clk(clk), .rst(rst), .push(in_xpos_valid), .pop(w_pop_t), .din(in_xpos),
        .dout(w_t_head), .full(w_t_full), .empty(w_t_empty)
    );

    xpos_arb_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo_inject (
        .clk(clk), .rst(rst), .push(inject_xpos_valid), .pop(w_pop_i), .din(inject_xpos),
        .dout(w_i_head), .full(w_i_full), .empty(w_i_empty)
    );

    assign in_xpos_ready     = !w_t_full;
    assign inject_xpos_ready = !w_i_full;

    assign w_load_en = !r_vld_p1 || out_xpos_ready;
    assign w_any     = !w_t_empty || !w_i_empty;
    assign w_pop_t   = w_load_en && w_any && (w_grant == SRC_TRANSIT);
    assign w_pop_i   = w_load_en && w_any && (w_grant == SRC_INJECT);

    always_comb begin
        w_grant = SRC_TRANSIT;
        if (!w_t_empty && !w_i_empty)
            w_grant = (r_rr_last == SRC_TRANSIT) ? SRC_INJECT : SRC_TRANSIT;
        else if (w_t_empty)
            w_grant = SRC_INJECT;
    end

    // Stage p1: registered output, arbiter history and grant counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_p1  <= '0;
            r_vld_p1  <= 1'b0;
            r_rr_last <= SRC_INJECT;
            r_cnt_t   <= '0;
            r_cnt_i   <= '0;
        end else if (w_load_en) begin
            if (w_any) begin
                r_out_p1  <= (w_grant == SRC_TRANSIT) ? w_t_head : w_i_head;
                r_vld_p1  <= 1'b1;
                r_rr_last <= w_grant;
                if (w_pop_t) r_cnt_t <= sat_inc(r_cnt_t);
                if (w_pop_i) r_cnt_i <= sat_inc(r_cnt_i);
            end else begin
                r_vld_p1  <= 1'b0;
            end
        end
    end

    assign out_xpos          = r_out_p1;
    assign out_xpos_valid    = r_vld_p1;
    assign grant_cnt_transit = r_cnt_t;
    assign grant_cnt_inject  = r_cnt_i;

endmodule
